kfps2kb_receive_data: RTL and testbench
=======================================

KFPS2KB_RECEIVE_DATA -- requirements
Module: kfps2kb_receive_data

Interface
REQ-001 SHALL have parameter device_in_timeout, default 16'd2000: peripheral_clock rising edges allowed between device_clock falling edges before a frame is abandoned.
REQ-002 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port peripheral_clock  input  1  slow timebase, sampled on clock; counts on its synchronised rising edge.
REQ-005 SHALL have port device_clock  input  1  PS/2 clock line from the keyboard, asynchronous.
REQ-006 SHALL have port device_data  input  1  PS/2 data line from the keyboard, asynchronous.
REQ-007 SHALL have port sending_data_flag  input  1  high while the host-to-device sender owns the bus; inhibits reception.
REQ-008 SHALL have port read_ack  input  1  one-cycle pulse: consumer has taken received_data.
REQ-009 SHALL have port received_data  output  8  last accepted scan byte.
REQ-010 SHALL have port data_valid  output  1  received_data holds an unread byte.
REQ-011 SHALL have port parity_error  output  1  sticky: a frame failed odd parity.
REQ-012 SHALL have port framing_error  output  1  sticky: a frame had stop bit 0.
REQ-013 SHALL have port timeout_error  output  1  sticky: a frame was abandoned by timeout.
REQ-014 SHALL have port overrun  output  1  sticky: a good frame arrived while data_valid=1.
REQ-015 SHALL have port receiving_flag  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL pass device_clock, device_data and peripheral_clock each through a 2-flop synchroniser; all edge detection uses the synchronised values (2-3 clock latency).
REQ-017 SHALL define a device_clock falling edge as synchronised previous=1, current=0; device_data is sampled in that same cycle.
REQ-018 SHALL implement states IDLE, DATA, PARITY, STOP, COMMIT.
REQ-019 IDLE: on a falling edge with data=0, go to DATA with bit_count=0; a falling edge with data=1 is ignored.
REQ-020 DATA: on each falling edge shift the data bit in LSB-first; after the 8th bit go to PARITY.
REQ-021 PARITY: on a falling edge capture the parity bit and go to STOP.
REQ-022 STOP: on a falling edge capture the stop bit and go to COMMIT.
REQ-023 COMMIT: lasts exactly one clock, then returns to IDLE.
REQ-024 Parity SHALL be odd: the 8 data bits plus the parity bit contain an odd number of ones.
REQ-025 In COMMIT, a parity failure SHALL set parity_error and discard the byte.
REQ-026 In COMMIT, stop=0 SHALL set framing_error and discard the byte; both errors may set together.
REQ-027 In COMMIT, a good frame with data_valid=0, or with read_ack in the same cycle, SHALL load received_data and set data_valid; received_data updates the cycle after COMMIT.
REQ-028 In COMMIT, a good frame with data_valid=1 and no read_ack SHALL keep the old received_data and set overrun.
REQ-029 read_ack SHALL clear data_valid, parity_error, framing_error, timeout_error and overrun, except where REQ-027 sets data_valid in the same cycle.
REQ-030 A 16-bit timeout counter SHALL reset on every state change and on every falling edge, and increment on each peripheral_clock rising edge while in DATA, PARITY or STOP.
REQ-031 When the timeout counter equals device_in_timeout, SHALL go to IDLE, set timeout_error and discard the partial byte.
REQ-032 While sending_data_flag=1, SHALL force IDLE, clear bit_count and the timeout counter, set no flags, and ignore edges; sticky flags and data_valid are held.

Reset
REQ-033 On reset: state IDLE, shift register, bit_count and timeout counter 0, synchronisers 1.
REQ-034 On reset: received_data=8'h00, data_valid=0, all error flags 0, receiving_flag=0.
REQ-035 Reset mid-frame SHALL abandon the frame with no flag set.

Structure
REQ-036 SHALL take state encodings and the default device_in_timeout from the shared kfps2kb package.
REQ-037 SHALL place the 2-flop synchroniser and edge detector in sub-module kfps2kb_sync_edge (outputs level, rise, fall), instantiated three times.

Verification
REQ-038 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> received_data=8'h1C, data_valid=1, no errors.
REQ-039 Frame 0xF0 with parity 0 -> parity_error=1, data_valid=0; then read_ack -> parity_error=0.
REQ-040 Stop after 4 data bits, idle >2000 peripheral_clock ticks -> timeout_error=1, IDLE; next frame 0xAA (parity 1) -> received_data=8'hAA.
REQ-041 Frames 0x1C then 0x32 with no read_ack -> received_data=8'h1C, overrun=1; read_ack in 0x32's COMMIT cycle instead -> received_data=8'h32, overrun=0.
REQ-042 sending_data_flag=1 during a 0x55 frame -> data_valid stays 0, no errors set; reset asserted mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/kfps2kb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : kfps2kb_pkg
// Shared receiver state encodings, defaults and frame helpers.
// Rev    : 1.0
// ----------------------------------------------------------------------------
package kfps2kb_pkg;

  localparam int STATE_W     = 3;
  localparam int TIMEOUT_W   = 16;
  localparam int BIT_COUNT_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DATA   = 3'd1;
  localparam state_t ST_PARITY = 3'd2;
  localparam state_t ST_STOP   = 3'd3;
  localparam state_t ST_COMMIT = 3'd4;

  localparam logic [TIMEOUT_W-1:0]   DEFAULT_DEVICE_IN_TIMEOUT = 16'd2000;
  localparam logic [BIT_COUNT_W-1:0] LAST_DATA_BIT             = 3'd7;

  typedef struct packed {
    logic parity;
    logic framing;
    logic timeout;
    logic overrun;
  } err_flags_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity_bit);
    return ^{data, parity_bit};
  endfunction

endpackage
`default_nettype wire

// File: rtl/kfps2kb_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : kfps2kb_sync_edge
// Two-flop synchroniser with rising/falling edge detection on the synced level.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module kfps2kb_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Idle PS/2 lines float high, so the chain resets to 1 to avoid a fake edge.
  always_ff @(posedge clock or posedge reset) begin : p_sync
    if (reset) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign level = r_sync;
  assign rise  = r_sync & ~r_prev;
  assign fall  = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/kfps2kb_receive_data.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : kfps2kb_receive_data
// PS/2 device-to-host frame receiver with timeout and sticky error reporting.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module kfps2kb_receive_data
  import kfps2kb_pkg::*;
#(
  parameter logic [15:0] device_in_timeout = DEFAULT_DEVICE_IN_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       peripheral_clock,
  input  logic       device_clock,
  input  logic       device_data,
  input  logic       sending_data_flag,
  input  logic       read_ack,
  output logic [7:0] received_data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       timeout_error,
  output logic       overrun,
  output logic       receiving_flag
);

  logic w_dclk_level;
  logic w_dclk_rise;
  logic w_dclk_fall;
  logic w_ddat_level;
  logic w_ddat_rise;
  logic w_ddat_fall;
  logic w_pclk_level;
  logic w_pclk_rise;
  logic w_pclk_fall;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [7:0]             r_shift;
  logic [BIT_COUNT_W-1:0] r_bit_count;
  logic                   r_parity_bit;
  logic                   r_stop_bit;
  logic [TIMEOUT_W-1:0]   r_timeout_count;

  logic [7:0]             r_received_data;
  logic                   r_data_valid;
  err_flags_t             r_err;

  logic w_in_frame;
  logic w_timeout_hit;
  logic w_commit;
  logic w_parity_ok;
  logic w_frame_good;

  kfps2kb_sync_edge u_sync_dclk (
    .clock    (clock),
    .reset    (reset),
    .async_in (device_clock),
    .level    (w_dclk_level),
    .rise     (w_dclk_rise),
    .fall     (w_dclk_fall)
  );

  kfps2kb_sync_edge u_sync_ddat (
    .clock    (clock),
    .reset    (reset),
    .async_in (device_data),
    .level    (w_ddat_level),
    .rise     (w_ddat_rise),
    .fall     (w_ddat_fall)
  );

  kfps2kb_sync_edge u_sync_pclk (
    .clock    (clock),
    .reset    (reset),
    .async_in (peripheral_clock),
    .level    (w_pclk_level),
    .rise     (w_pclk_rise),
    .fall     (w_pclk_fall)
  );

  // Only falling device_clock, data level and rising peripheral_clock matter here.
  logic [5:0] w_unused_edges;
  assign w_unused_edges = {w_dclk_level, w_dclk_rise, w_ddat_rise,
                           w_ddat_fall, w_pclk_level, w_pclk_fall};

  assign w_in_frame    = (r_state == ST_DATA) || (r_state == ST_PARITY) ||
                         (r_state == ST_STOP);
  assign w_timeout_hit = w_in_frame && !sending_data_flag &&
                         (r_timeout_count == device_in_timeout);
  assign w_commit      = (r_state == ST_COMMIT) && !sending_data_flag;
  assign w_parity_ok   = odd_parity_ok(r_shift, r_parity_bit);
  assign w_frame_good  = w_parity_ok && r_stop_bit;

  always_ff @(posedge clock or posedge reset) begin : p_state_reg
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin : p_next_state
    w_state_next = r_state;
    if (sending_data_flag || w_timeout_hit) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_dclk_fall && !w_ddat_level) w_state_next = ST_DATA;
        ST_DATA:   if (w_dclk_fall && (r_bit_count == LAST_DATA_BIT)) w_state_next = ST_PARITY;
        ST_PARITY: if (w_dclk_fall) w_state_next = ST_STOP;
        ST_STOP:   if (w_dclk_fall) w_state_next = ST_COMMIT;
        ST_COMMIT: w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin : p_outputs
    receiving_flag = (r_state != ST_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin : p_datapath
    if (reset) begin
      r_shift         <= '0;
      r_bit_count     <= '0;
      r_parity_bit    <= 1'b0;
      r_stop_bit      <= 1'b0;
      r_timeout_count <= '0;
    end else if (sending_data_flag) begin
      r_bit_count     <= '0;
      r_timeout_count <= '0;
    end else begin
      if ((w_state_next != r_state) || w_dclk_fall) begin
        r_timeout_count <= '0;
      end else if (w_in_frame && w_pclk_rise) begin
        r_timeout_count <= r_timeout_count + TIMEOUT_W'(1);
      end

      if (w_dclk_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_ddat_level) begin
              r_bit_count <= '0;
              r_shift     <= '0;
            end
          end
          ST_DATA: begin
            r_shift     <= {w_ddat_level, r_shift[7:1]};
            r_bit_count <= r_bit_count + BIT_COUNT_W'(1);
          end
          ST_PARITY: r_parity_bit <= w_ddat_level;
          ST_STOP:   r_stop_bit   <= w_ddat_level;
          default: ;
        endcase
      end
    end
  end

  // An acknowledge clears everything first so a same-cycle commit can re-set it.
  always_ff @(posedge clock or posedge reset) begin : p_status
    if (reset) begin
      r_received_data <= 8'h00;
      r_data_valid    <= 1'b0;
      r_err           <= '0;
    end else begin
      if (read_ack) begin
        r_data_valid <= 1'b0;
        r_err        <= '0;
      end

      if (w_timeout_hit) begin
        r_err.timeout <= 1'b1;
      end

      if (w_commit) begin
        if (!w_parity_ok) begin
          r_err.parity <= 1'b1;
        end
        if (!r_stop_bit) begin
          r_err.framing <= 1'b1;
        end
        if (w_frame_good) begin
          if (!r_data_valid || read_ack) begin
            r_received_data <= r_shift;
            r_data_valid    <= 1'b1;
          end else begin
            r_err.overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign received_data = r_received_data;
  assign data_valid    = r_data_valid;
  assign parity_error  = r_err.parity;
  assign framing_error = r_err.framing;
  assign timeout_error = r_err.timeout;
  assign overrun       = r_err.overrun;

endmodule
`default_nettype wire

// File: tb/tb_kfps2kb_receive_data.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_kfps2kb_receive_data
// Randomised PS/2 frame stimulus checked against a frame-level reference model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_kfps2kb_receive_data;

  logic       clock             = 1'b0;
  logic       reset             = 1'b1;
  logic       peripheral_clock  = 1'b0;
  logic       device_clock      = 1'b1;
  logic       device_data       = 1'b1;
  logic       sending_data_flag = 1'b0;
  logic       read_ack          = 1'b0;
  logic [7:0] received_data;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       timeout_error;
  logic       overrun;
  logic       receiving_flag;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_data;
  bit         m_valid, m_par, m_frm, m_to, m_ovr;

  kfps2kb_receive_data dut (
    .clock             (clock),
    .reset             (reset),
    .peripheral_clock  (peripheral_clock),
    .device_clock      (device_clock),
    .device_data       (device_data),
    .sending_data_flag (sending_data_flag),
    .read_ack          (read_ack),
    .received_data     (received_data),
    .data_valid        (data_valid),
    .parity_error      (parity_error),
    .framing_error     (framing_error),
    .timeout_error     (timeout_error),
    .overrun           (overrun),
    .receiving_flag    (receiving_flag)
  );

  always #5 clock = ~clock;
  // One peripheral tick every four system clocks.
  always #20 peripheral_clock = ~peripheral_clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit expired, expected completion");
    $fatal(1);
  end

  function automatic bit odd_ok(input logic [7:0] d, input bit p);
    return ($countones({d, p}) % 2) == 1;
  endfunction

  function automatic bit good_parity(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  function automatic void model_reset();
    m_data = 8'h00; m_valid = 0; m_par = 0; m_frm = 0; m_to = 0; m_ovr = 0;
  endfunction

  function automatic void model_ack();
    m_valid = 0; m_par = 0; m_frm = 0; m_to = 0; m_ovr = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input bit p, input bit s, input bit ack);
    if (ack) model_ack();
    if (!odd_ok(d, p)) m_par = 1;
    if (!s) m_frm = 1;
    if (odd_ok(d, p) && s) begin
      if (!m_valid) begin
        m_data  = d;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end
  endfunction

  task automatic pulse_ack();
    read_ack = 1'b1;
    @(negedge clock);
    read_ack = 1'b0;
    @(negedge clock);
    model_ack();
  endtask

  // bits[0]=start, bits[8:1]=data LSB first, bits[9]=parity, bits[10]=stop.
  // With ack_commit the acknowledge lands in the commit cycle after the stop edge.
  task automatic drive_bits(input logic [10:0] bits, input int nbits, input bit ack_commit);
    int hp;
    for (int i = 0; i < nbits; i++) begin
      hp = $urandom_range(8, 14);
      device_data = bits[i];
      repeat (hp) @(negedge clock);
      device_clock = 1'b0;
      if (ack_commit && i == 10) begin
        repeat (3) @(negedge clock);
        read_ack = 1'b1;
        @(negedge clock);
        read_ack = 1'b0;
        repeat (hp - 4) @(negedge clock);
      end else begin
        repeat (hp) @(negedge clock);
      end
      device_clock = 1'b1;
    end
    device_data = 1'b1;
    repeat (6) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit p, input bit s, input bit ack);
    drive_bits({s, p, d, 1'b0}, 11, ack);
    model_frame(d, p, s, ack);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_reset();
    n_checks++; if (received_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", received_data); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", data_valid); else n_pass++;
    n_checks++; if (parity_error !== 1'b0) $display("FAIL reset_parity: got %b expected 0", parity_error); else n_pass++;
    n_checks++; if (framing_error !== 1'b0) $display("FAIL reset_framing: got %b expected 0", framing_error); else n_pass++;
    n_checks++; if (timeout_error !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", timeout_error); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
    n_checks++; if (receiving_flag !== 1'b0) $display("FAIL reset_receiving: got %b expected 0", receiving_flag); else n_pass++;
  endtask

  task automatic test_good_frame();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    n_checks++; if (received_data !== 8'h1C) $display("FAIL good_data: got %h expected 1c", received_data); else n_pass++;
    n_checks++; if (data_valid !== 1'b1) $display("FAIL good_valid: got %b expected 1", data_valid); else n_pass++;
    n_checks++; if ({parity_error, framing_error, overrun} !== 3'b000) $display("FAIL good_errors: got %b expected 000", {parity_error, framing_error, overrun}); else n_pass++;
    pulse_ack();
    n_checks++; if (data_valid !== 1'b0) $display("FAIL good_ack_valid: got %b expected 0", data_valid); else n_pass++;
  endtask

  task automatic test_parity_error();
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    n_checks++; if (parity_error !== 1'b1) $display("FAIL parity_set: got %b expected 1", parity_error); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL parity_valid: got %b expected 0", data_valid); else n_pass++;
    pulse_ack();
    n_checks++; if (parity_error !== 1'b0) $display("FAIL parity_ack: got %b expected 0", parity_error); else n_pass++;
  endtask

  task automatic test_framing_error();
    logic [7:0] d;
    d = 8'($urandom);
    send_frame(d, good_parity(d), 1'b0, 1'b0);
    n_checks++; if (framing_error !== 1'b1) $display("FAIL framing_set: got %b expected 1", framing_error); else n_pass++;
    n_checks++; if (parity_error !== 1'b0) $display("FAIL framing_parity: got %b expected 0", parity_error); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL framing_valid: got %b expected 0", data_valid); else n_pass++;
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    n_checks++; if (received_data !== 8'h1C) $display("FAIL ovr_data: got %h expected 1c", received_data); else n_pass++;
    n_checks++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun); else n_pass++;
    n_checks++; if (data_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", data_valid); else n_pass++;
    pulse_ack();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b1);
    n_checks++; if (received_data !== 8'h32) $display("FAIL ackc_data: got %h expected 32", received_data); else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL ackc_overrun: got %b expected 0", overrun); else n_pass++;
    n_checks++; if (data_valid !== 1'b1) $display("FAIL ackc_valid: got %b expected 1", data_valid); else n_pass++;
    pulse_ack();
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit         p, s;
    int         kind, ack_mode;
    for (int n = 0; n < 24; n++) begin
      d        = 8'($urandom);
      kind     = $urandom_range(0, 9);
      ack_mode = $urandom_range(0, 2);
      p        = good_parity(d);
      if (kind == 0) p = ~p;
      s        = (kind == 1) ? 1'b0 : 1'b1;
      if (ack_mode == 1) pulse_ack();
      send_frame(d, p, s, ack_mode == 2);
      n_checks++; if (received_data !== m_data) $display("FAIL rnd_data[%0d]: got %h expected %h", n, received_data, m_data); else n_pass++;
      n_checks++; if (data_valid !== m_valid) $display("FAIL rnd_valid[%0d]: got %b expected %b", n, data_valid, m_valid); else n_pass++;
      n_checks++; if (parity_error !== m_par) $display("FAIL rnd_parity[%0d]: got %b expected %b", n, parity_error, m_par); else n_pass++;
      n_checks++; if (framing_error !== m_frm) $display("FAIL rnd_framing[%0d]: got %b expected %b", n, framing_error, m_frm); else n_pass++;
      n_checks++; if (timeout_error !== m_to) $display("FAIL rnd_timeout[%0d]: got %b expected %b", n, timeout_error, m_to); else n_pass++;
      n_checks++; if (overrun !== m_ovr) $display("FAIL rnd_overrun[%0d]: got %b expected %b", n, overrun, m_ovr); else n_pass++;
      n_checks++; if (receiving_flag !== 1'b0) $display("FAIL rnd_receiving[%0d]: got %b expected 0", n, receiving_flag); else n_pass++;
    end
    pulse_ack();
  endtask

  // Start bit plus four data bits, then silence; the abandon threshold is 2000 ticks.
  task automatic test_timeout();
    drive_bits({1'b1, 1'b1, 8'hAA, 1'b0}, 5, 1'b0);
    repeat (1850 * 4) @(negedge clock);
    n_checks++; if (receiving_flag !== 1'b1) $display("FAIL to_early_receiving: got %b expected 1", receiving_flag); else n_pass++;
    n_checks++; if (timeout_error !== 1'b0) $display("FAIL to_early_flag: got %b expected 0", timeout_error); else n_pass++;
    repeat (250 * 4) @(negedge clock);
    m_to = 1;
    n_checks++; if (timeout_error !== 1'b1) $display("FAIL to_flag: got %b expected 1", timeout_error); else n_pass++;
    n_checks++; if (receiving_flag !== 1'b0) $display("FAIL to_idle: got %b expected 0", receiving_flag); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL to_valid: got %b expected 0", data_valid); else n_pass++;
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
    n_checks++; if (received_data !== 8'hAA) $display("FAIL to_next_data: got %h expected aa", received_data); else n_pass++;
    n_checks++; if (timeout_error !== 1'b1) $display("FAIL to_sticky: got %b expected 1", timeout_error); else n_pass++;
    pulse_ack();
    n_checks++; if (timeout_error !== 1'b0) $display("FAIL to_ack: got %b expected 0", timeout_error); else n_pass++;
  endtask

  task automatic test_inhibit();
    logic [10:0] fr;
    fr = {1'b1, 1'b1, 8'h55, 1'b0};
    drive_bits(fr, 1, 1'b0);
    sending_data_flag = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++; if (receiving_flag !== 1'b0) $display("FAIL inh_receiving: got %b expected 0", receiving_flag); else n_pass++;
    drive_bits(fr >> 1, 10, 1'b0);
    sending_data_flag = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++; if (data_valid !== 1'b0) $display("FAIL inh_valid: got %b expected 0", data_valid); else n_pass++;
    n_checks++; if ({parity_error, framing_error, timeout_error, overrun} !== 4'b0000)
      $display("FAIL inh_errors: got %b expected 0000", {parity_error, framing_error, timeout_error, overrun}); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'($urandom);
    send_frame(d, good_parity(d), 1'b1, 1'b0);
    n_checks++; if (data_valid !== 1'b1) $display("FAIL rmf_pre_valid: got %b expected 1", data_valid); else n_pass++;
    drive_bits({1'b1, 1'b1, 8'h3C, 1'b0}, 4, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    model_reset();
    n_checks++; if (received_data !== 8'h00) $display("FAIL rmf_data: got %h expected 00", received_data); else n_pass++;
    n_checks++; if (data_valid !== 1'b0) $display("FAIL rmf_valid: got %b expected 0", data_valid); else n_pass++;
    n_checks++; if ({parity_error, framing_error, timeout_error, overrun} !== 4'b0000)
      $display("FAIL rmf_errors: got %b expected 0000", {parity_error, framing_error, timeout_error, overrun}); else n_pass++;
    n_checks++; if (receiving_flag !== 1'b0) $display("FAIL rmf_receiving: got %b expected 0", receiving_flag); else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_back_to_back();
    test_random();
    test_timeout();
    test_inhibit();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
